bfs_run_controller: RTL and testbench

- Run sequencer directly downstream of the CSR block. Consumes its start/config outputs and produces the busy, done and incr_traversed_edges status inputs.
- On a start rising edge it snapshots configuration and fetches the start-node descriptor over a simple read-request port. It classifies the node degree against the thresholds, launches the traversal engine, then counts edges until the engine finishes, errors, or times out.

---
 rtl/bfs_run_controller.sv | 195 +++++++++++++++++++
 tb/tb_bfs_run_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfs_run_controller.sv
// BFS run sequencer: on a start rise it fetches the start-node descriptor,
// classifies its degree, launches the traversal engine and counts edges until done/abort.
module bfs_run_controller #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TMO_WIDTH      = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  control_reg_start,
    input  logic [DATA_WIDTH-1:0] start_node_address,
    input  logic [DATA_WIDTH-1:0] graph_base_address,
    input  logic [DATA_WIDTH-1:0] high_degree_threshold,
    input  logic [DATA_WIDTH-1:0] medium_degree_threshold,
    output logic                  busy,
    output logic                  done,
    output logic                  run_error,
    output logic                  incr_traversed_edges,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    input  logic                  mem_resp_err,
    output logic                  eng_start,
    input  logic                  eng_ready,
    output logic [DATA_WIDTH-1:0] eng_edge_ptr,
    output logic [DATA_WIDTH-1:0] eng_degree,
    output logic [1:0]            eng_mode,
    input  logic                  eng_edge_valid,
    input  logic                  eng_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_RESP     = 3'd3;
    localparam logic [2:0] S_CLASSIFY = 3'd4;
    localparam logic [2:0] S_DISPATCH = 3'd5;
    localparam logic [2:0] S_RUN      = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]            state_q, state_d;
    logic                  prev_q;
    logic [DATA_WIDTH-1:0] base_q, base_d, node_q, node_d;
    logic [DATA_WIDTH-1:0] high_q, high_d, med_q, med_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, ptr_q, ptr_d, deg_q, deg_d;
    logic [1:0]            mode_q, mode_d;
    logic                  beat_q, beat_d;
    logic [TMO_WIDTH-1:0]  wdog_q, wdog_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d, incr_q, incr_d;
    logic                  start_rise;

    assign start_rise = control_reg_start & ~prev_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        node_d  = node_q;
        high_d  = high_q;
        med_d   = med_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        deg_d   = deg_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        wdog_d  = wdog_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        incr_d  = (state_q == S_RUN) & eng_edge_valid;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_rise) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    base_d  = graph_base_address;
                    node_d  = start_node_address;
                    high_d  = high_degree_threshold;
                    med_d   = medium_degree_threshold;
                end
            end
            S_LOAD: begin
                addr_d  = base_q + node_q;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_req_ready) begin
                    beat_d  = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_resp_valid) begin
                    if (mem_resp_err) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (!beat_q) begin
                        ptr_d  = mem_resp_data;
                        beat_d = 1'b1;
                    end else begin
                        deg_d   = mem_resp_data;
                        state_d = S_CLASSIFY;
                    end
                end
            end
            S_CLASSIFY: begin
                // High is tested first so an inverted threshold pair still resolves.
                if (deg_q >= high_q)     mode_d = 2'd2;
                else if (deg_q >= med_q) mode_d = 2'd1;
                else                     mode_d = 2'd0;
                state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (eng_ready) begin
                    wdog_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (eng_done) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (TMO_EN && wdog_q == TMO_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            prev_q  <= 1'b0;
            base_q  <= '0;
            node_q  <= '0;
            high_q  <= '0;
            med_q   <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
            deg_q   <= '0;
            mode_q  <= '0;
            beat_q  <= 1'b0;
            wdog_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            incr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= control_reg_start;
            base_q  <= base_d;
            node_q  <= node_d;
            high_q  <= high_d;
            med_q   <= med_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            deg_q   <= deg_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            wdog_q  <= wdog_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            incr_q  <= incr_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign run_error            = err_q;
    assign incr_traversed_edges = incr_q;
    assign mem_req_valid        = (state_q == S_FETCH);
    assign mem_req_addr         = addr_q;
    assign eng_start            = (state_q == S_DISPATCH) & eng_ready;
    assign eng_edge_ptr         = ptr_q;
    assign eng_degree           = deg_q;
    assign eng_mode             = mode_q;

endmodule

// File: tb/tb_bfs_run_controller.sv
// Scoreboard bench for bfs_run_controller: directed runs push expectations,
// a negedge monitor pops and compares whenever the DUT presents a request, launch or done.
module tb_bfs_run_controller;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] ptr;
        logic [31:0] deg;
    } eng_t;

    typedef struct {
        logic err;
        int   edges;
        int   lat;
    } done_t;

    typedef struct {
        logic [31:0] base, node, hi, med, ptr, deg;
        int          rdy_dly;
        bit          err0;
        int          nedges;
        int          done_cyc;
        bit          toggle;
        logic [31:0] exp_addr;
        logic [1:0]  exp_mode;
        bit          exp_err;
        int          exp_edges;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        control_reg_start;
    logic [31:0] start_node_address, graph_base_address;
    logic [31:0] high_degree_threshold, medium_degree_threshold;
    logic        busy, done, run_error, incr_traversed_edges;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid, mem_resp_err;
    logic [31:0] mem_resp_data;
    logic        eng_start, eng_ready;
    logic [31:0] eng_edge_ptr, eng_degree;
    logic [1:0]  eng_mode;
    logic        eng_edge_valid, eng_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int incr_cnt = 0;
    logic done_prev = 1'b0;

    logic [31:0] addr_q[$];
    eng_t        eng_q[$];
    done_t       done_q[$];

    vec_t vecs[12];

    bfs_run_controller #(
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16),
        .TMO_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .control_reg_start(control_reg_start),
        .start_node_address(start_node_address),
        .graph_base_address(graph_base_address),
        .high_degree_threshold(high_degree_threshold),
        .medium_degree_threshold(medium_degree_threshold),
        .busy(busy),
        .done(done),
        .run_error(run_error),
        .incr_traversed_edges(incr_traversed_edges),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .mem_resp_err(mem_resp_err),
        .eng_start(eng_start),
        .eng_ready(eng_ready),
        .eng_edge_ptr(eng_edge_ptr),
        .eng_degree(eng_degree),
        .eng_mode(eng_mode),
        .eng_edge_valid(eng_edge_valid),
        .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_run_error"}, run_error, 0);
        check({tag, "_incr"}, incr_traversed_edges, 0);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_req_addr"}, mem_req_addr, 0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_edge_ptr"}, eng_edge_ptr, 0);
        check({tag, "_degree"}, eng_degree, 0);
        check({tag, "_mode"}, eng_mode, 0);
    endtask

    // Monitor: samples on the falling edge, away from input changes and state updates.
    initial begin : monitor
        eng_t  e;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst) begin
                incr_cnt  = 0;
                done_prev = 1'b0;
            end else begin
                if (incr_traversed_edges) begin
                    incr_cnt++;
                    check("incr_only_in_run", busy | (done & ~done_prev), 1);
                end
                if (mem_req_valid) begin
                    if (addr_q.size() == 0) fail_now("unexpected_mem_req");
                    else begin
                        check("req_addr", mem_req_addr, addr_q[0]);
                        if (mem_req_ready) void'(addr_q.pop_front());
                    end
                end
                if (eng_start) begin
                    if (eng_q.size() == 0) fail_now("unexpected_eng_start");
                    else begin
                        e = eng_q.pop_front();
                        check("eng_mode", eng_mode, e.mode);
                        check("eng_edge_ptr", eng_edge_ptr, e.ptr);
                        check("eng_degree", eng_degree, e.deg);
                    end
                    incr_cnt  = 0;
                    start_cyc = cyc;
                end
                if (done && !done_prev) begin
                    if (done_q.size() == 0) fail_now("unexpected_done");
                    else begin
                        d = done_q.pop_front();
                        check("run_error", run_error, d.err);
                        check("busy_at_done", busy, 0);
                        check("edge_pulses", incr_cnt, d.edges);
                        if (d.lat >= 0) check("done_latency", cyc - start_cyc, d.lat);
                    end
                    incr_cnt = 0;
                end
                done_prev = done;
            end
            cyc++;
        end
    end

    task automatic run(input vec_t v, input bit from_rst, input bit abort_rst);
        bit seen;
        addr_q.push_back(v.exp_addr);
        if (!v.err0) eng_q.push_back('{v.exp_mode, v.ptr, v.deg});
        if (!abort_rst) done_q.push_back('{v.exp_err, v.exp_edges, v.exp_lat});
        graph_base_address      = v.base;
        start_node_address      = v.node;
        high_degree_threshold   = v.hi;
        medium_degree_threshold = v.med;
        if (from_rst) begin
            rst = 1'b0;
        end else begin
            control_reg_start = 1'b0;
            tick();
            control_reg_start = 1'b1;
        end
        tick();
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("error_cleared", run_error, 0);
        // Config must have been snapshotted; scramble the live inputs.
        graph_base_address      = $urandom;
        start_node_address      = $urandom;
        high_degree_threshold   = $urandom;
        medium_degree_threshold = $urandom;

        for (int i = 0; i < 20 && !mem_req_valid; i++) tick();
        if (!mem_req_valid) begin
            fail_now("no_mem_req");
            return;
        end
        repeat (v.rdy_dly) tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.ptr;
        mem_resp_err   = v.err0;
        eng_edge_valid = 1'b1;
        tick();
        mem_resp_data = v.deg;
        mem_resp_err  = 1'b0;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        eng_edge_valid = 1'b0;
        if (v.err0) begin
            repeat (8) tick();
            check("done_after_err", done, 1);
            return;
        end

        eng_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (eng_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            fail_now("no_eng_start");
            eng_ready = 1'b0;
            return;
        end
        tick();
        eng_ready = 1'b0;

        for (int c = 0; c < 40; c++) begin
            eng_edge_valid = (c < v.nedges);
            eng_done       = (c == v.done_cyc);
            if (v.toggle && c >= 1 && c <= 4) control_reg_start = (c % 2 == 0);
            tick();
            if (abort_rst && c == 1) begin
                rst = 1'b1;
                #1;
                check_outputs_zero("async_reset");
                eng_edge_valid = 1'b0;
                eng_done       = 1'b0;
                repeat (3) tick();
                return;
            end
            if (done) break;
        end
        eng_done = 1'b0;
        if (!done) fail_now("run_never_done");
        eng_edge_valid = 1'b1;
        repeat (2) tick();
        eng_edge_valid = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        vec_t vr;
        rst = 1'b1;
        control_reg_start = 1'b0;
        start_node_address = '0;
        graph_base_address = '0;
        high_degree_threshold = '0;
        medium_degree_threshold = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        mem_resp_err = 1'b0;
        eng_ready = 1'b0;
        eng_edge_valid = 1'b0;
        eng_done = 1'b0;

        //         base          node   hi           med          ptr          deg           rdy err n  dcyc tog exp_addr      mode err edges lat
        vecs[0]  = '{32'h1000_0000, 32'h40, 32'd100, 32'd10, 32'h2000, 32'd150, 0, 0, 5, 5, 0, 32'h1000_0040, 2'd2, 0, 5, 7};
        vecs[1]  = '{32'h0000_0100, 32'h08, 32'd100, 32'd10, 32'h00a0, 32'd9,   2, 0, 2, 3, 0, 32'h0000_0108, 2'd0, 0, 2, 5};
        vecs[2]  = '{32'h0000_0100, 32'h10, 32'd100, 32'd10, 32'h00b0, 32'd10,  0, 0, 3, 2, 0, 32'h0000_0110, 2'd1, 0, 3, 4};
        vecs[3]  = '{32'h0000_0100, 32'h18, 32'd100, 32'd10, 32'h00c0, 32'd99,  1, 0, 0, 0, 0, 32'h0000_0118, 2'd1, 0, 0, 2};
        vecs[4]  = '{32'h0000_0100, 32'h20, 32'd100, 32'd10, 32'h00d0, 32'd100, 0, 0, 1, 1, 0, 32'h0000_0120, 2'd2, 0, 1, 3};
        vecs[5]  = '{32'h0000_0200, 32'h04, 32'd50,  32'd200, 32'h00e0, 32'd60, 0, 0, 2, 4, 0, 32'h0000_0204, 2'd2, 0, 2, 6};
        vecs[6]  = '{32'h0000_0300, 32'h00, 32'h10,  32'h08, 32'h00f0, 32'h8000_0000, 0, 0, 1, 2, 0, 32'h0000_0300, 2'd2, 0, 1, 4};
        vecs[7]  = '{32'h0000_4000, 32'h80, 32'd100, 32'd10, 32'h1111, 32'd5,   7, 1, 0, 0, 0, 32'h0000_4080, 2'd0, 1, 0, -1};
        vecs[8]  = '{32'h0000_5000, 32'h10, 32'd100, 32'd10, 32'h2222, 32'd20,  0, 0, 3, -1, 0, 32'h0000_5010, 2'd1, 1, 3, 17};
        vecs[9]  = '{32'h0000_6000, 32'h10, 32'd100, 32'd10, 32'h3333, 32'd0,   0, 0, 0, 15, 0, 32'h0000_6010, 2'd0, 0, 0, 17};
        vecs[10] = '{32'h0000_7000, 32'h10, 32'd0,   32'd0,  32'h4444, 32'd0,   0, 0, 2, 8, 1, 32'h0000_7010, 2'd2, 0, 2, 10};
        vecs[11] = '{32'hFFFF_FFF0, 32'h20, 32'd100, 32'd10, 32'h5555, 32'd11,  3, 0, 4, 4, 0, 32'h0000_0010, 2'd1, 0, 4, 6};

        repeat (2) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_req_valid", mem_req_valid, 0);

        foreach (vecs[i]) run(vecs[i], 1'b0, 1'b0);

        // Abort in RUN with an edge pulse pending, start held high through reset.
        vr = '{32'h0000_8000, 32'h30, 32'd100, 32'd10, 32'h6666, 32'd150, 0, 0, 4, -1, 0, 32'h0000_8030, 2'd2, 0, 0, -1};
        run(vr, 1'b0, 1'b1);
        vr = '{32'h0000_9000, 32'h44, 32'd100, 32'd10, 32'h7777, 32'd50,  0, 0, 2, 3, 0, 32'h0000_9044, 2'd1, 0, 2, 5};
        run(vr, 1'b1, 1'b0);

        repeat (4) tick();
        check("addr_queue_drained", addr_q.size(), 0);
        check("eng_queue_drained", eng_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
